// File: rtl/crc_rx_err_filter.sv
// crc_rx_err_filter
// Sits behind the CRC32 receive decoder on the flit path. Good flits are
// buffered in a small FIFO toward a valid/ready consumer. Corrupted or
// overflowing flits trigger a retry request with the expected sequence
// number. Traffic is then dropped until the link layer signals replay start.
// The retry is re-requested every TIMEOUT cycles while waiting.
//
// Optional build macro: CRC_RX_STATS_EN
//   defined   -> saturating err/drop statistics counters are built
//   undefined -> counters are omitted and err_cnt_o/drop_cnt_o read as 0
module crc_rx_err_filter #(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH      = 4,
  parameter int SEQ_WIDTH  = 8,
  parameter int TIMEOUT    = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  detected_i,
  input  logic                  replay_start_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i,
  output logic                  retry_req_o,
  output logic [SEQ_WIDTH-1:0]  retry_seq_o,
  output logic                  state_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic [CNT_WIDTH-1:0]  drop_cnt_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {
    S_NORMAL     = 1'b0,
    S_RETRY_WAIT = 1'b1
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;

  // Control state
  state_t                r_state;
  logic                  r_retry_req;
  logic [SEQ_WIDTH-1:0]  r_retry_seq;
  logic [SEQ_WIDTH-1:0]  r_exp_seq;
  logic [TW-1:0]         r_timer;

  // Datapath decisions for the current cycle
  logic w_pop;
  logic w_push_legal;
  logic w_normal_rules;
  logic w_push;
  logic w_discard_normal;

  // A flit is judged by NORMAL rules either in NORMAL or on the replay-start
  // cycle, where it is the first replayed flit.
  assign w_pop            = (r_count != '0) && ready_i;
  assign w_push_legal     = (r_count < DEPTH_C) || w_pop;
  assign w_normal_rules   = (r_state == S_NORMAL) || replay_start_i;
  assign w_push           = valid_i && w_normal_rules && !detected_i && w_push_legal;
  assign w_discard_normal = valid_i && w_normal_rules && !w_push;

  // Head of FIFO drives the output; zero when nothing is buffered.
  assign valid_o = (r_count != '0);
  assign data_o  = valid_o ? r_mem[r_rd_ptr] : '0;

  assign retry_req_o = r_retry_req;
  assign retry_seq_o = r_retry_seq;
  assign state_o     = r_state;

  // FIFO storage write (no reset so it maps onto plain memory)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // FIFO pointers and occupancy; full with simultaneous pop still accepts
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Retry FSM: sequence tracking, retry pulses, timeout re-requests
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_NORMAL;
      r_retry_req <= 1'b0;
      r_retry_seq <= '0;
      r_exp_seq   <= '0;
      r_timer     <= '0;
    end else begin
      r_retry_req <= 1'b0;
      if (w_push) begin
        r_exp_seq <= r_exp_seq + 1'b1;
      end
      if (w_discard_normal) begin
        // Corrupted or overflowing flit: ask for replay from the first
        // sequence number we have not accepted.
        r_retry_req <= 1'b1;
        r_retry_seq <= r_exp_seq;
        r_state     <= S_RETRY_WAIT;
        r_timer     <= '0;
      end else if (r_state == S_RETRY_WAIT) begin
        if (replay_start_i) begin
          // Replay beats a coinciding timeout; no pulse is issued.
          r_state <= S_NORMAL;
          r_timer <= '0;
        end else if (r_timer == TIMER_LAST) begin
          r_retry_req <= 1'b1;
          r_timer     <= '0;
        end else begin
          r_timer <= r_timer + 1'b1;
        end
      end
    end
  end

`ifdef CRC_RX_STATS_EN
  logic [CNT_WIDTH-1:0] r_err_cnt;
  logic [CNT_WIDTH-1:0] r_drop_cnt;
  logic                 w_err_inc;
  logic                 w_drop_inc;

  // Every flagged flit is an error; every flit not pushed is a drop.
  assign w_err_inc  = valid_i && detected_i;
  assign w_drop_inc = valid_i && !w_push;

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_err_inc && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
      if (w_drop_inc && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign err_cnt_o  = r_err_cnt;
  assign drop_cnt_o = r_drop_cnt;
`else
  assign err_cnt_o  = '0;
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_crc_rx_err_filter.sv
// Directed testbench for crc_rx_err_filter (DEPTH=4, TIMEOUT=8, CNT_WIDTH=4).
// Counter expectations follow CRC_RX_STATS_EN: live counts when defined,
// constant zero otherwise.
module tb_crc_rx_err_filter;
  localparam int DW = 512;
  localparam int DP = 4;
  localparam int SW = 8;
  localparam int TO = 8;
  localparam int CW = 4;
`ifdef CRC_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          detected_i;
  logic          replay_start_i;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          ready_i;
  logic          retry_req_o;
  logic [SW-1:0] retry_seq_o;
  logic          state_o;
  logic [CW-1:0] err_cnt_o;
  logic [CW-1:0] drop_cnt_o;

  int errors = 0;
  int checks = 0;
  int n_err  = 0;
  int n_drop = 0;

  crc_rx_err_filter #(
    .DATA_WIDTH(DW), .DEPTH(DP), .SEQ_WIDTH(SW), .TIMEOUT(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i),
    .detected_i(detected_i), .replay_start_i(replay_start_i),
    .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
    .retry_req_o(retry_req_o), .retry_seq_o(retry_seq_o), .state_o(state_o),
    .err_cnt_o(err_cnt_o), .drop_cnt_o(drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] cnt_exp(input int n);
    if (!STATS) return '0;
    return (n > 15) ? DW'(15) : DW'(n);
  endfunction

  task automatic chk_cnt(input string tag);
    chk({tag, "_err_cnt"}, err_cnt_o, cnt_exp(n_err));
    chk({tag, "_drop_cnt"}, drop_cnt_o, cnt_exp(n_drop));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic det, input logic rs);
    valid_i        = v;
    data_i         = d;
    detected_i     = det;
    replay_start_i = rs;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    rst    = 1'b0;
    n_err  = 0;
    n_drop = 0;
  endtask

  initial begin
    logic exp_pulse;
    ready_i = 1'b1;
    do_reset();

    // Reset state
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_retry", retry_req_o, 1'b0);
    chk("rst_seq", retry_seq_o, '0);
    chk("rst_state", state_o, 1'b0);
    chk("rst_data", data_o, '0);
    chk_cnt("rst");
    $display("reset: valid_o=%0b state_o=%0b", valid_o, state_o);

    // Three good flits, consumer always ready: one cycle latency, in order
    drive(1'b1, DW'('hA), 1'b0, 1'b0); tick();
    chk("t1_valid_a", valid_o, 1'b1); chk("t1_data_a", data_o, DW'('hA)); chk("t1_req_a", retry_req_o, 1'b0);
    drive(1'b1, DW'('hB), 1'b0, 1'b0); tick();
    chk("t1_data_b", data_o, DW'('hB)); chk("t1_req_b", retry_req_o, 1'b0);
    drive(1'b1, DW'('hC), 1'b0, 1'b0); tick();
    chk("t1_data_c", data_o, DW'('hC)); chk("t1_req_c", retry_req_o, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0); tick();
    chk("t1_empty", valid_o, 1'b0);
    // Expose expected_seq through a bad flit
    drive(1'b1, DW'('hEE), 1'b1, 1'b0); tick(); n_err++; n_drop++;
    chk("t1_req", retry_req_o, 1'b1); chk("t1_expseq", retry_seq_o, SW'(3));
    $display("test1: three flits, retry_seq_o=%0d", retry_seq_o);

    // Two good flits held, then a corrupted flit
    do_reset();
    ready_i = 1'b0;
    drive(1'b1, DW'('h11), 1'b0, 1'b0); tick();
    drive(1'b1, DW'('h12), 1'b0, 1'b0); tick();
    drive(1'b1, DW'('hBAD), 1'b1, 1'b0); tick(); n_err++; n_drop++;
    chk("t2_req", retry_req_o, 1'b1); chk("t2_seq", retry_seq_o, SW'(2));
    chk("t2_state", state_o, 1'b1); chk("t2_head", data_o, DW'('h11));
    chk_cnt("t2");
    $display("test2: retry_req_o=%0b retry_seq_o=%0d", retry_req_o, retry_seq_o);

    // Five flits dropped in RETRY_WAIT while the buffered flits drain
    ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, DW'(32'h20 + i), 1'b0, 1'b0); tick(); n_drop++;
      chk("t3_req_low", retry_req_o, 1'b0);
      chk("t3_state", state_o, 1'b1);
      chk("t3_seq_hold", retry_seq_o, SW'(2));
      if (i == 0) chk("t3_drain_12", data_o, DW'('h12));
      if (i == 1) chk("t3_drained", valid_o, 1'b0);
    end
    chk_cnt("t3_drops");
    drive(1'b1, DW'('hD), 1'b0, 1'b1); tick();
    chk("t3_state_norm", state_o, 1'b0); chk("t3_valid_d", valid_o, 1'b1); chk("t3_data_d", data_o, DW'('hD));
    chk_cnt("t3_replay");
    drive(1'b0, '0, 1'b0, 1'b0); tick();
    drive(1'b1, DW'('hBAD), 1'b1, 1'b0); tick(); n_err++; n_drop++;
    chk("t3_req", retry_req_o, 1'b1); chk("t3_expseq", retry_seq_o, SW'(3));
    $display("test3: after replay retry_seq_o=%0d drop_cnt_o=%0d", retry_seq_o, drop_cnt_o);

    // Overflow: four fit, fifth triggers retry
    do_reset();
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DW'(32'h40 + i), 1'b0, 1'b0); tick();
      chk("t4_req_low", retry_req_o, 1'b0);
    end
    chk("t4_head", data_o, DW'('h40));
    drive(1'b1, DW'('h44), 1'b0, 1'b0); tick(); n_drop++;
    chk("t4_ovf_req", retry_req_o, 1'b1); chk("t4_ovf_seq", retry_seq_o, SW'(4));
    chk("t4_ovf_state", state_o, 1'b1); chk_cnt("t4_ovf");
    $display("test4a: overflow retry_seq_o=%0d", retry_seq_o);

    // Full with simultaneous pop accepts the fifth flit
    do_reset();
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DW'(32'h40 + i), 1'b0, 1'b0); tick();
    end
    ready_i = 1'b1;
    drive(1'b1, DW'('h44), 1'b0, 1'b0); tick();
    chk("t4_full_pop_req", retry_req_o, 1'b0); chk("t4_full_pop_state", state_o, 1'b0);
    chk("t4_full_pop_head", data_o, DW'('h41));
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 2; i < 5; i++) begin
      tick();
      chk("t4_drain", data_o, DW'(32'h40 + i));
    end
    tick();
    chk("t4_empty", valid_o, 1'b0); chk_cnt("t4_full_pop");
    $display("test4b: full with pop accepted, state_o=%0b", state_o);

    // Timeout re-requests every TO cycles, replay on expiry suppresses pulse
    do_reset();
    drive(1'b1, DW'('hBAD), 1'b1, 1'b0); tick(); n_err++; n_drop++;
    chk("t5_first_req", retry_req_o, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 23; i++) begin
      tick();
      exp_pulse = (i == 8) || (i == 16);
      chk($sformatf("t5_req_c%0d", i), retry_req_o, exp_pulse);
      if (exp_pulse) chk("t5_req_seq", retry_seq_o, SW'(0));
    end
    drive(1'b0, '0, 1'b0, 1'b1); tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t5_replay_nopulse", retry_req_o, 1'b0); chk("t5_replay_state", state_o, 1'b0);
    tick();
    chk("t5_after_req", retry_req_o, 1'b0); chk_cnt("t5");
    $display("test5: timeout pulses checked, state_o=%0b", state_o);

    // Counter saturation
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, DW'(32'h900 + i), 1'b1, 1'b0); tick(); n_err++; n_drop++;
      if (i >= 14) chk_cnt($sformatf("t6_sat%0d", i));
    end
    $display("test6: err_cnt_o=%0d drop_cnt_o=%0d", err_cnt_o, drop_cnt_o);

    // Reset in RETRY_WAIT with a non-empty FIFO
    ready_i = 1'b0;
    drive(1'b1, DW'('h77), 1'b0, 1'b1); tick();
    chk("t7_state_norm", state_o, 1'b0); chk("t7_data", data_o, DW'('h77));
    drive(1'b1, DW'('h88), 1'b1, 1'b0); tick(); n_err++; n_drop++;
    chk("t7_state_rw", state_o, 1'b1); chk("t7_valid_pre", valid_o, 1'b1);
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0); tick();
    n_err = 0; n_drop = 0;
    chk("t7_valid", valid_o, 1'b0); chk("t7_state", state_o, 1'b0);
    chk("t7_req", retry_req_o, 1'b0); chk("t7_data0", data_o, '0);
    chk("t7_seq", retry_seq_o, '0);
    chk_cnt("t7");
    rst = 1'b0;
    tick();
    chk("t7_req_after", retry_req_o, 1'b0);
    $display("test7: reset mid-retry valid_o=%0b state_o=%0b", valid_o, state_o);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
